// File: rtl/vector_path_engine_if.sv
`default_nettype none
//==============================================================================
// Module   : vector_path_engine_if
// Brief    : Run control and XY point outputs of the vector path engine.
// Revision : 1.0 - initial release
//==============================================================================
interface vector_path_engine_if;
    logic       run;
    logic [7:0] x;
    logic [6:0] y;
    logic       valid;
    logic       trig;
    logic       blank;
    logic       frame_done;

    modport master (input run, output x, y, valid, trig, blank, frame_done);
    modport slave  (output run, input x, y, valid, trig, blank, frame_done);
endinterface
`default_nettype wire

// File: rtl/vector_path_engine.sv
`default_nettype none
//==============================================================================
// Module   : vector_path_engine
// Brief    : Walks a 6-segment display list, Bresenham-rasterises each line
//            into XY points for the BNC outputs. Macro VEC_SETTLE_EN adds a
//            blanked settle before discontinuous segments.
// Revision : 1.0 - initial release
//==============================================================================
module vector_path_engine #(
    parameter int DWELL         = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input wire                   clk,
    input wire                   rst_n,
    vector_path_engine_if.master bus
);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_draw = 2'd2;
`ifdef VEC_SETTLE_EN
    localparam logic [1:0] c_settle      = 2'd3;
    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
`endif
    localparam logic [7:0] c_dwell_last  = 8'(DWELL - 1);
    localparam logic [2:0] c_last_seg    = 3'd5;

    if (DWELL < 1 || DWELL > 255 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_param_check
        $error("vector_path_engine: DWELL and SETTLE_CYCLES must be 1..255");
    end

    logic [1:0]         r_state;
    logic [2:0]         r_seg;
    logic [7:0]         r_dwell;
    logic [7:0]         r_x;
    logic [6:0]         r_y;
    logic               r_valid;
    logic               r_trig;
    logic               r_frame_done;
    logic signed [10:0] r_dx;
    logic signed [10:0] r_dy;
    logic signed [10:0] r_err;
    logic               r_sx;
    logic               r_sy;
`ifdef VEC_SETTLE_EN
    logic               r_blank;
    logic [7:0]         r_settle;
`endif

    logic [7:0]         w_x0, w_x1;
    logic [6:0]         w_y0, w_y1;
    logic signed [10:0] w_x0s, w_x1s, w_y0s, w_y1s;
    logic signed [10:0] w_dx, w_dy, w_e2, w_err_next;
    logic               w_step_x, w_step_y, w_at_end;

    // Display list ROM; segment 0 takes the defaults.
    always_comb begin
        w_x0 = 8'd32;
        w_y0 = 7'd16;
        w_x1 = 8'd224;
        w_y1 = 7'd16;
        case (r_seg)
            3'd1:    begin w_x0 = 8'd224; w_y0 = 7'd16;  w_x1 = 8'd224; w_y1 = 7'd80;  end
            3'd2:    begin w_x0 = 8'd224; w_y0 = 7'd80;  w_x1 = 8'd128; w_y1 = 7'd120; end
            3'd3:    begin w_x0 = 8'd128; w_y0 = 7'd120; w_x1 = 8'd32;  w_y1 = 7'd80;  end
            3'd4:    begin w_x0 = 8'd32;  w_y0 = 7'd80;  w_x1 = 8'd32;  w_y1 = 7'd16;  end
            3'd5:    begin w_x0 = 8'd112; w_y0 = 7'd16;  w_x1 = 8'd144; w_y1 = 7'd48;  end
            default: ;
        endcase
    end

    assign w_x0s = $signed({3'b000, w_x0});
    assign w_x1s = $signed({3'b000, w_x1});
    assign w_y0s = $signed({4'b0000, w_y0});
    assign w_y1s = $signed({4'b0000, w_y1});
    assign w_dx  = (w_x1s >= w_x0s) ? (w_x1s - w_x0s) : (w_x0s - w_x1s);
    assign w_dy  = (w_y1s >= w_y0s) ? (w_y0s - w_y1s) : (w_y1s - w_y0s);

    assign w_e2       = r_err <<< 1;
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : 11'sd0) + (w_step_y ? r_dx : 11'sd0);
    assign w_at_end   = (r_x == w_x1) && (r_y == w_y1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_seg        <= 3'd0;
            r_dwell      <= 8'd0;
            r_x          <= 8'd0;
            r_y          <= 7'd0;
            r_valid      <= 1'b0;
            r_trig       <= 1'b0;
            r_frame_done <= 1'b0;
            r_dx         <= 11'sd0;
            r_dy         <= 11'sd0;
            r_err        <= 11'sd0;
            r_sx         <= 1'b0;
            r_sy         <= 1'b0;
`ifdef VEC_SETTLE_EN
            r_blank      <= 1'b0;
            r_settle     <= 8'd0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.run) begin
                        r_state <= c_load;
                        r_seg   <= 3'd0;
                    end
                end
                c_load: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_err   <= w_dx + w_dy;
                    r_sx    <= (w_x1 >= w_x0);
                    r_sy    <= (w_y1 >= w_y0);
                    r_dwell <= 8'd0;
                    r_x     <= w_x0;
                    r_y     <= w_y0;
`ifdef VEC_SETTLE_EN
                    // r_x/r_y still hold the last emitted point here
                    if ((w_x0 != r_x) || (w_y0 != r_y)) begin
                        r_state  <= c_settle;
                        r_blank  <= 1'b1;
                        r_settle <= 8'd0;
                    end else
`endif
                    begin
                        r_state <= c_draw;
                        r_valid <= 1'b1;
                        r_trig  <= (r_seg == 3'd0);
                    end
                end
`ifdef VEC_SETTLE_EN
                c_settle: begin
                    if (r_settle == c_settle_last) begin
                        r_state <= c_draw;
                        r_blank <= 1'b0;
                        r_valid <= 1'b1;
                        r_trig  <= (r_seg == 3'd0);
                    end else begin
                        r_settle <= r_settle + 8'd1;
                    end
                end
`endif
                c_draw: begin
                    if (r_dwell != c_dwell_last) begin
                        r_dwell <= r_dwell + 8'd1;
                    end else begin
                        r_dwell <= 8'd0;
                        r_trig  <= 1'b0;
                        if (w_at_end) begin
                            r_valid <= 1'b0;
                            if (r_seg == c_last_seg) begin
                                r_seg        <= 3'd0;
                                r_frame_done <= 1'b1;
                                r_state      <= bus.run ? c_load : c_idle;
                            end else begin
                                r_seg   <= r_seg + 3'd1;
                                r_state <= c_load;
                            end
                        end else begin
                            if (w_step_x) r_x <= r_sx ? (r_x + 8'd1) : (r_x - 8'd1);
                            if (w_step_y) r_y <= r_sy ? (r_y + 7'd1) : (r_y - 7'd1);
                            r_err <= w_err_next;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.valid      = r_valid;
    assign bus.trig       = r_trig;
    assign bus.frame_done = r_frame_done;
`ifdef VEC_SETTLE_EN
    assign bus.blank      = r_blank;
`else
    assign bus.blank      = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vector_path_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_vector_path_engine
// Brief    : Self-checking bench: vector table, frame-level sequences and a
//            cycle reference model under random run/reset activity.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vector_path_engine;
`ifdef VEC_SETTLE_EN
    localparam int c_gap = 4;
`else
    localparam int c_gap = 0;
`endif
    localparam int c_period1 = 550 * 1 + 6 + 2 * c_gap;
    localparam int c_period3 = 550 * 3 + 6 + 2 * c_gap;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    vector_path_engine_if bus1 ();
    vector_path_engine_if bus3 ();

    vector_path_engine #(.DWELL(1), .SETTLE_CYCLES(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
    vector_path_engine #(.DWELL(3), .SETTLE_CYCLES(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- reference model (DWELL = 1 instance) ----------------
    typedef struct { int x; int y; bit valid; bit trig; bit blank; bit fd; } out_t;

    int   seg_x0 [6] = '{32, 224, 224, 128, 32, 112};
    int   seg_y0 [6] = '{16, 16, 80, 120, 80, 16};
    int   seg_x1 [6] = '{224, 224, 128, 32, 32, 144};
    int   seg_y1 [6] = '{16, 80, 120, 80, 16, 48};
    out_t q[$];
    out_t cur;
    bit   m_idle, m_en;
    int   m_lx, m_ly;

    task automatic push_rec(input int x, input int y, input bit v, input bit t, input bit b, input bit fd);
        out_t r;
        r.x = x; r.y = y; r.valid = v; r.trig = t; r.blank = b; r.fd = fd;
        q.push_back(r);
    endtask

    task automatic build_frame(input bit fd);
        int x, y, x1, y1, dx, dy, sx, sy, err, e2;
        bit first;
        for (int s = 0; s < 6; s++) begin
            push_rec(m_lx, m_ly, 0, 0, 0, (s == 0) ? fd : 1'b0);
            if (c_gap != 0 && (seg_x0[s] != m_lx || seg_y0[s] != m_ly))
                for (int k = 0; k < c_gap; k++) push_rec(seg_x0[s], seg_y0[s], 0, 0, 1, 0);
            x = seg_x0[s]; y = seg_y0[s]; x1 = seg_x1[s]; y1 = seg_y1[s];
            dx = (x1 > x) ? x1 - x : x - x1;
            dy = (y1 > y) ? y - y1 : y1 - y;
            sx = (x1 >= x) ? 1 : -1;
            sy = (y1 >= y) ? 1 : -1;
            err = dx + dy;
            first = 1;
            while (1) begin
                push_rec(x, y, 1, (s == 0) && first, 0, 0);
                first = 0;
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
            m_lx = x1; m_ly = y1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            cur = '{0, 0, 0, 0, 0, 0};
            m_idle = 1; m_lx = 0; m_ly = 0; m_en = 1;
        end else if (m_en) begin
            cur.fd = 0;
            if (q.size() == 0) begin
                if (m_idle) begin
                    if (bus1.run) begin build_frame(0); m_idle = 0; end
                end else if (bus1.run) begin
                    build_frame(1);
                end else begin
                    m_idle = 1; cur.valid = 0; cur.trig = 0; cur.fd = 1;
                end
            end
            if (q.size() != 0) cur = q.pop_front();
        end
    end

    always @(negedge clk) begin
        if (m_en)
            check(bus1.x == cur.x && bus1.y == cur.y && bus1.valid == cur.valid &&
                  bus1.trig == cur.trig && bus1.blank == cur.blank && bus1.frame_done == cur.fd,
                  "model",
                  $sformatf("cyc %0d got x=%0d y=%0d v=%0b t=%0b b=%0b fd=%0b want x=%0d y=%0d v=%0b t=%0b b=%0b fd=%0b",
                            cyc, bus1.x, bus1.y, bus1.valid, bus1.trig, bus1.blank, bus1.frame_done,
                            cur.x, cur.y, cur.valid, cur.trig, cur.blank, cur.fd));
    end

    // ---------------- directed vectors ----------------
    typedef struct { int c; int x; int y; bit v; bit t; bit fd; } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input int c, input int x, input int y, input bit v, input bit t, input bit fd);
        vec_t e;
        e.c = c; e.x = x; e.y = y; e.v = v; e.t = t; e.fd = fd;
        tbl.push_back(e);
    endtask

    int t0, t1, n_inval, n_trig, n, runs, bad, len, rx, ry, guard;
    bit prev, active, hit;

    initial begin
        n_checks = 0; n_pass = 0; m_en = 0; cyc = 0;
        add_vec(0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(2 + c_gap, 32, 16, 1, 1, 0);
        add_vec(3 + c_gap, 33, 16, 1, 0, 0);
        add_vec(194 + c_gap, 224, 16, 1, 0, 0);
        add_vec(195 + c_gap, 224, 16, 0, 0, 0);
        add_vec(262 + c_gap, 224, 80, 1, 0, 0);
        add_vec(263 + c_gap, 223, 80, 1, 0, 0);
        add_vec(264 + c_gap, 222, 81, 1, 0, 0);
        add_vec(358 + c_gap, 128, 120, 1, 0, 0);
        add_vec(359 + c_gap, 128, 120, 0, 0, 0);
        add_vec(524 + 2 * c_gap, 112, 16, 1, 0, 0);
        add_vec(556 + 2 * c_gap, 144, 48, 1, 0, 0);
        add_vec(557 + 2 * c_gap, 144, 48, 0, 0, 1);
        add_vec(558 + 3 * c_gap, 32, 16, 1, 1, 0);

        rst_n = 0; bus1.run = 0; bus3.run = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; bus1.run = 1; bus3.run = 1;

        foreach (tbl[i]) begin
            guard = 0;
            while (cyc != tbl[i].c && guard < 2000) begin @(negedge clk); guard++; end
            check(cyc == tbl[i].c && bus1.x == tbl[i].x && bus1.y == tbl[i].y && bus1.valid == tbl[i].v &&
                  bus1.trig == tbl[i].t && bus1.frame_done == tbl[i].fd && bus1.blank == 1'b0,
                  $sformatf("vec%0d", i),
                  $sformatf("cyc %0d got x=%0d y=%0d v=%0b t=%0b fd=%0b want cyc %0d x=%0d y=%0d v=%0b t=%0b fd=%0b",
                            cyc, bus1.x, bus1.y, bus1.valid, bus1.trig, bus1.frame_done,
                            tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].t, tbl[i].fd));
        end

        // steady frame period and blank-cycle count, DWELL=1
        t0 = -1; t1 = -1;
        for (int k = 0; k < 2000; k++) begin @(negedge clk); if (bus1.frame_done) begin t0 = cyc; break; end end
        n_inval = 1; n_trig = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus1.frame_done) begin t1 = cyc; break; end
            if (!bus1.valid) n_inval++;
            if (bus1.trig) n_trig++;
        end
        check(t0 >= 0 && t1 >= 0 && t1 - t0 == c_period1, "period1",
              $sformatf("got %0d want %0d", t1 - t0, c_period1));
        check(n_inval == 6 + 2 * c_gap, "invalid_cycles", $sformatf("got %0d want %0d", n_inval, 6 + 2 * c_gap));
        check(n_trig == 1, "trig_width1", $sformatf("got %0d want 1", n_trig));

        // DWELL=3 instance: hold length per point and frame period
        prev = bus3.trig; hit = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (bus3.trig && !prev) begin hit = 1; break; end
            prev = bus3.trig;
        end
        n = 0; runs = 0; bad = 0; len = 1; active = 1; rx = bus3.x; ry = bus3.y; n_trig = 1; t1 = -1;
        for (int k = 0; k < 4000 && hit; k++) begin
            prev = bus3.trig;
            @(negedge clk); n++;
            if (bus3.trig && !prev) begin t1 = n; break; end
            if (bus3.trig) n_trig++;
            if (bus3.valid && active && bus3.x == rx && bus3.y == ry) len++;
            else begin
                if (active) begin runs++; if (len != 3) bad++; end
                active = bus3.valid; rx = bus3.x; ry = bus3.y; len = 1;
            end
        end
        check(t1 == c_period3, "period3", $sformatf("got %0d want %0d", t1, c_period3));
        check(runs == 550 && bad == 0, "dwell3_hold", $sformatf("got %0d points, %0d wrong length; want 550, 0", runs, bad));
        check(n_trig == 3, "trig_width3", $sformatf("got %0d want 3", n_trig));

        // drop run during segment 2
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus1.valid && bus1.x == 223 && bus1.y == 80) begin hit = 1; break; end
        end
        bus1.run = 0;
        t0 = -1;
        for (int k = 0; k < 2000 && hit; k++) begin @(negedge clk); if (bus1.frame_done) begin t0 = k; break; end end
        check(t0 >= 0 && bus1.x == 144 && bus1.y == 48 && !bus1.valid, "stop_done",
              $sformatf("got fd_seen=%0b x=%0d y=%0d v=%0b want 1 144 48 0", t0 >= 0, bus1.x, bus1.y, bus1.valid));
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.valid || bus1.frame_done || bus1.trig || bus1.x != 144 || bus1.y != 48) bad++;
        end
        check(bad == 0, "idle_hold", $sformatf("got %0d bad cycles want 0", bad));
        bus1.run = 1;
        @(negedge clk);
        check(!bus1.valid && bus1.x == 144 && bus1.y == 48, "restart_load",
              $sformatf("got v=%0b x=%0d y=%0d want 0 144 48", bus1.valid, bus1.x, bus1.y));
        repeat (c_gap) @(negedge clk);
        @(negedge clk);
        check(bus1.valid && bus1.trig && bus1.x == 32 && bus1.y == 16, "restart_first",
              $sformatf("got v=%0b t=%0b x=%0d y=%0d want 1 1 32 16", bus1.valid, bus1.trig, bus1.x, bus1.y));

        // random run toggling with occasional resets, model-checked
        for (int i = 0; i < 14; i++) begin
            bus1.run = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin rst_n = 0; @(negedge clk); rst_n = 1; end
            repeat ($urandom_range(1, 700)) @(negedge clk);
        end

        // reset mid-operation (during settle when present, else mid-draw)
        rst_n = 0; @(negedge clk); rst_n = 1; bus1.run = 1;
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ((c_gap != 0) ? bus1.blank : (bus1.valid && bus1.x == 100)) begin hit = 1; break; end
        end
        rst_n = 0;
        @(negedge clk);
        check(hit && bus1.x == 0 && bus1.y == 0 && !bus1.valid && !bus1.trig && !bus1.blank && !bus1.frame_done,
              "mid_reset", $sformatf("got reached=%0b x=%0d y=%0d v=%0b t=%0b b=%0b fd=%0b want all 1/0",
                                     hit, bus1.x, bus1.y, bus1.valid, bus1.trig, bus1.blank, bus1.frame_done));
        rst_n = 1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
